// File: rtl/wb_block_master.sv
// Wishbone classic-cycle block initiator: streams a block of 32-bit words
// to or from a responder, one single-word cycle per word, with a gap clock.
// Ports: cmd_* block command in; wdata/wvalid/wready write stream;
// rdata/rvalid read stream; busy/done/err status; wb_* Wishbone initiator.
// Optional: define WB_BLOCK_MASTER_TIMEOUT_EN for the per-word ack timeout.
module wb_block_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_len,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        wready,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_addr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {
    IDLE, FETCH, BUS, GAP, DONE
  } state_t;

  state_t      state;
  state_t      nxt;
  logic        alive;
  logic        we_r;
  logic [31:0] addr_r;
  logic [15:0] cnt;
  logic [31:0] data_r;
  logic [31:0] rdata_r;
  logic        rvalid_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic        accept;
  logic        ack;
  logic        expire;

  assign accept = cmd_ready & cmd_valid;
  assign ack    = (state == BUS) & wb_ack_i;

`ifdef WB_BLOCK_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  // An ack on the expiry edge wins, so expiry is qualified by !ack.
  assign expire = (state == BUS) & ~wb_ack_i &
                  (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if (state != BUS)
      to_cnt <= '0;
    else if (!wb_ack_i)
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (accept) begin
          if (cmd_len == 16'd0) nxt = DONE;
          else if (cmd_we)      nxt = FETCH;
          else                  nxt = BUS;
        end
      FETCH:
        if (wvalid) nxt = BUS;
      BUS:
        if (wb_ack_i)    nxt = GAP;
        else if (expire) nxt = DONE;
      GAP:
        if (cnt == 16'd0) nxt = DONE;
        else if (we_r)    nxt = FETCH;
        else              nxt = BUS;
      DONE:
        nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  // cmd_ready is gated by alive so it stays low during reset and
  // rises on the first clock after release.
  always_comb begin
    cmd_ready = alive & (state == IDLE);
    wready    = (state == FETCH);
    wb_cyc_o  = (state == BUS);
    wb_stb_o  = (state == BUS);
    wb_we_o   = (state == BUS) & we_r;
    wb_sel_o  = (state == BUS) ? 4'hF : 4'h0;
  end

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      alive    <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      cnt      <= '0;
      data_r   <= '0;
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      alive    <= 1'b1;
      rvalid_r <= ack & ~we_r;
      done_r   <= (state == DONE);
      if (accept) begin
        we_r   <= cmd_we;
        addr_r <= cmd_addr & 32'hFFFF_FFFC;
        cnt    <= cmd_len;
        err_r  <= 1'b0;
        busy_r <= 1'b1;
      end
      if ((state == FETCH) && wvalid)
        data_r <= wdata;
      if (ack) begin
        cnt    <= cnt - 16'd1;
        addr_r <= addr_r + 32'd4;
        if (!we_r)
          rdata_r <= wb_data_i;
      end
      if (expire)
        err_r <= 1'b1;
      if (state == DONE)
        busy_r <= 1'b0;
    end
  end

  assign wb_addr_o = addr_r;
  assign wb_data_o = data_r;
  assign rdata     = rdata_r;
  assign rvalid    = rvalid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_wb_block_master.sv
// Directed bench for wb_block_master: read, write, len 0, address wrap,
// optional ack timeout, and asynchronous reset in the middle of a cycle.
module tb_wb_block_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        busy;
  logic        done;
  logic        err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_addr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;

  always #5 clk = ~clk;

  wb_block_master #(.TIMEOUT(8)) dut (
    .wb_clk_i(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid),
    .busy(busy), .done(done), .err(err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_sel_o(wb_sel_o),
    .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
    .wb_ack_i(wb_ack_i)
  );

  int tests = 0;
  int fails = 0;

  int          n_cyc, n_rv, done_cnt, done_k, tmo, wr_bad;
  logic [31:0] c_addr [8];
  logic [31:0] c_dat  [8];
  logic        c_we   [8];
  logic [3:0]  c_sel  [8];
  int          c_start[8];
  int          c_ack  [8];
  int          c_len  [8];
  logic [31:0] rv_dat [8];
  int          rv_k   [8];
  logic        err_done, busy_done;

  task automatic run_block(input logic we, input logic [31:0] addr,
                           input logic [15:0] len, input int lat,
                           input int wdly, input logic [31:0] wd0,
                           input logic [31:0] wd1, input int max);
    int k, age, fage;
    logic prev;
    n_cyc = 0; n_rv = 0; done_cnt = 0; done_k = 0; tmo = 0; wr_bad = 0;
    err_done = 1'bx; busy_done = 1'bx;
    for (int i = 0; i < 8; i++) begin
      c_start[i] = 0; c_ack[i] = 0; c_len[i] = 0; rv_k[i] = 0;
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    prev = 1'b0; age = 0; fage = 0; k = 1;
    while (1) begin
      if (wb_stb_o && !prev) begin
        if (n_cyc < 8) begin
          c_addr[n_cyc] = wb_addr_o; c_dat[n_cyc] = wb_data_o;
          c_we[n_cyc] = wb_we_o; c_sel[n_cyc] = wb_sel_o;
          c_start[n_cyc] = k;
        end
        n_cyc++; age = 0;
      end
      if (wb_stb_o) begin
        age++;
        if (n_cyc <= 8) c_len[n_cyc-1]++;
      end
      if (wb_cyc_o !== wb_stb_o) wr_bad++;
      if (rvalid) begin
        if (n_rv < 8) begin rv_dat[n_rv] = rdata; rv_k[n_rv] = k; end
        n_rv++;
      end
      if (wready && (wb_cyc_o || !busy)) wr_bad++;
      if (done) begin
        done_cnt++; done_k = k; err_done = err; busy_done = busy;
      end
      prev = wb_stb_o;
      wb_ack_i = 1'b0; wb_data_i = '0; wvalid = 1'b0; wdata = '0;
      if (wb_stb_o && lat > 0 && age == lat) begin
        wb_ack_i = 1'b1;
        wb_data_i = 32'(32'hA0 + n_cyc - 1);
        if (n_cyc <= 8) c_ack[n_cyc-1] = k;
      end
      if (wready) begin
        fage++;
        if (fage > wdly) begin
          wvalid = 1'b1; wdata = (n_cyc == 0) ? wd0 : wd1; fage = 0;
        end
      end
      if (done_cnt > 0 && k > done_k) break;
      if (k >= max) begin tmo = 1; break; end
      k++;
      @(negedge clk);
    end
    wb_ack_i = 1'b0; wb_data_i = '0; wvalid = 1'b0; wdata = '0;
  endtask

  task automatic test_reset();
    #12;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b want 0", cmd_ready); end
    tests++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'd0) begin fails++; $display("FAIL rst_bus got %b%b%b%h want 0", wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o); end
    tests++; if ({busy, done, err, wready, rvalid} !== 5'd0) begin fails++; $display("FAIL rst_status got %b want 0", {busy, done, err, wready, rvalid}); end
    tests++; if ({wb_addr_o, wb_data_o, rdata} !== 96'd0) begin fails++; $display("FAIL rst_data got %h %h %h want 0", wb_addr_o, wb_data_o, rdata); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rel_ready_early got %b want 0", cmd_ready); end
    @(negedge clk);
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rel_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_read();
    run_block(1'b0, 32'h100, 16'd3, 4, 0, '0, '0, 60);
    tests++; if (tmo !== 0) begin fails++; $display("FAIL rd_tmo got %0d want 0", tmo); end
    tests++; if (n_cyc !== 3) begin fails++; $display("FAIL rd_ncyc got %0d want 3", n_cyc); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (c_addr[i] !== 32'h100 + 32'(4*i)) begin fails++; $display("FAIL rd_addr%0d got %h want %h", i, c_addr[i], 32'h100 + 32'(4*i)); end
      tests++; if ({c_we[i], c_sel[i]} !== 5'b0_1111) begin fails++; $display("FAIL rd_we_sel%0d got %b want 01111", i, {c_we[i], c_sel[i]}); end
      tests++; if (rv_dat[i] !== 32'hA0 + 32'(i)) begin fails++; $display("FAIL rd_data%0d got %h want %h", i, rv_dat[i], 32'hA0 + 32'(i)); end
      tests++; if (rv_k[i] !== c_ack[i] + 1) begin fails++; $display("FAIL rd_rv_time%0d got %0d want %0d", i, rv_k[i], c_ack[i] + 1); end
    end
    tests++; if (c_start[0] !== 1) begin fails++; $display("FAIL rd_first_stb got %0d want 1", c_start[0]); end
    tests++; if (c_start[1] !== c_ack[0] + 2 || c_start[2] !== c_ack[1] + 2) begin fails++; $display("FAIL rd_gap got %0d %0d want %0d %0d", c_start[1], c_start[2], c_ack[0] + 2, c_ack[1] + 2); end
    tests++; if (n_rv !== 3) begin fails++; $display("FAIL rd_nrv got %0d want 3", n_rv); end
    tests++; if (done_cnt !== 1 || done_k !== 17) begin fails++; $display("FAIL rd_done got %0d@%0d want 1@17", done_cnt, done_k); end
    tests++; if ({err_done, busy_done} !== 2'b00) begin fails++; $display("FAIL rd_err_busy got %b want 00", {err_done, busy_done}); end
    tests++; if (wr_bad !== 0) begin fails++; $display("FAIL rd_proto got %0d want 0", wr_bad); end
  endtask

  task automatic test_write();
    run_block(1'b1, 32'h2000, 16'd2, 2, 3, 32'hDEADBEEF, 32'h12345678, 60);
    tests++; if (tmo !== 0 || n_cyc !== 2) begin fails++; $display("FAIL wr_ncyc got %0d tmo %0d want 2", n_cyc, tmo); end
    tests++; if (c_addr[0] !== 32'h2000 || c_addr[1] !== 32'h2004) begin fails++; $display("FAIL wr_addr got %h %h want 2000 2004", c_addr[0], c_addr[1]); end
    tests++; if (c_dat[0] !== 32'hDEADBEEF || c_dat[1] !== 32'h12345678) begin fails++; $display("FAIL wr_data got %h %h want deadbeef 12345678", c_dat[0], c_dat[1]); end
    tests++; if ({c_we[0], c_sel[0], c_we[1], c_sel[1]} !== 10'b11111_11111) begin fails++; $display("FAIL wr_we_sel got %b want all 1", {c_we[0], c_sel[0], c_we[1], c_sel[1]}); end
    tests++; if (c_start[0] !== 5 || c_start[1] !== 12) begin fails++; $display("FAIL wr_stb_time got %0d %0d want 5 12", c_start[0], c_start[1]); end
    tests++; if (wr_bad !== 0 || n_rv !== 0) begin fails++; $display("FAIL wr_wready got bad %0d rv %0d want 0 0", wr_bad, n_rv); end
    tests++; if (done_cnt !== 1 || done_k !== 16 || busy_done !== 1'b0) begin fails++; $display("FAIL wr_done got %0d@%0d busy %b want 1@16 0", done_cnt, done_k, busy_done); end
  endtask

  task automatic test_len0();
    run_block(1'b0, 32'h300, 16'd0, 4, 0, '0, '0, 20);
    tests++; if (done_cnt !== 1 || done_k !== 2) begin fails++; $display("FAIL len0_done got %0d@%0d want 1@2", done_cnt, done_k); end
    tests++; if (n_cyc !== 0 || n_rv !== 0) begin fails++; $display("FAIL len0_cyc got %0d rv %0d want 0 0", n_cyc, n_rv); end
  endtask

  task automatic test_wrap();
    run_block(1'b0, 32'hFFFFFFFE, 16'd2, 1, 0, '0, '0, 40);
    tests++; if (n_cyc !== 2 || c_addr[0] !== 32'hFFFFFFFC) begin fails++; $display("FAIL wrap_addr0 got %h n %0d want fffffffc 2", c_addr[0], n_cyc); end
    tests++; if (c_addr[1] !== 32'h0) begin fails++; $display("FAIL wrap_addr1 got %h want 00000000", c_addr[1]); end
    tests++; if (done_cnt !== 1 || rv_dat[1] !== 32'hA1) begin fails++; $display("FAIL wrap_done got %0d %h want 1 a1", done_cnt, rv_dat[1]); end
  endtask

`ifdef WB_BLOCK_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    run_block(1'b0, 32'h400, 16'd4, 0, 0, '0, '0, 40);
    tests++; if (n_cyc !== 1 || c_len[0] !== 8) begin fails++; $display("FAIL to_len got %0d cyc %0d clk want 1 cyc 8 clk", n_cyc, c_len[0]); end
    tests++; if (done_cnt !== 1 || err_done !== 1'b1) begin fails++; $display("FAIL to_done got %0d err %b want 1 1", done_cnt, err_done); end
    tests++; if (n_rv !== 0) begin fails++; $display("FAIL to_rv got %0d want 0", n_rv); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL to_sticky got %b want 1", err); end
    run_block(1'b0, 32'h0, 16'd0, 0, 0, '0, '0, 20);
    tests++; if (err_done !== 1'b0) begin fails++; $display("FAIL to_clear got %b want 0", err_done); end
  endtask
`else
  task automatic test_slow_ack();
    run_block(1'b0, 32'h500, 16'd1, 20, 0, '0, '0, 60);
    tests++; if (n_cyc !== 1 || c_len[0] !== 20) begin fails++; $display("FAIL slow_len got %0d cyc %0d clk want 1 cyc 20 clk", n_cyc, c_len[0]); end
    tests++; if (err_done !== 1'b0 || rv_dat[0] !== 32'hA0) begin fails++; $display("FAIL slow_data got err %b %h want 0 a0", err_done, rv_dat[0]); end
  endtask
`endif

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h600; cmd_len = 16'd2;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    @(negedge clk);
    tests++; if (wb_cyc_o !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL mid_pre got cyc %b busy %b want 1 1", wb_cyc_o, busy); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({wb_cyc_o, wb_stb_o, busy, done} !== 4'b0) begin fails++; $display("FAIL mid_async got %b want 0000", {wb_cyc_o, wb_stb_o, busy, done}); end
    @(negedge clk);
    rst = 1'b0;
    run_block(1'b0, 32'h40, 16'd1, 2, 0, '0, '0, 40);
    tests++; if (n_cyc !== 1 || c_addr[0] !== 32'h40) begin fails++; $display("FAIL mid_after_cyc got %0d %h want 1 40", n_cyc, c_addr[0]); end
    tests++; if (n_rv !== 1 || rv_dat[0] !== 32'hA0 || done_cnt !== 1) begin fails++; $display("FAIL mid_after_rd got %0d %h done %0d want 1 a0 1", n_rv, rv_dat[0], done_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata = '0; wvalid = 1'b0; wb_data_i = '0; wb_ack_i = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_len0();
    test_wrap();
`ifdef WB_BLOCK_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_slow_ack();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
